prbs15_ber_window_ctrl: RTL and testbench

//  Measurement sequencer downstream of the PRBS15 byte checker. Drives the checker's reset/stop inputs
//  and consumes its bit_errors/locked outputs.
//  Per start request: clear checker, qualify lock, measure over a fixed window of clock cycles,

---
 rtl/prbs15_ber_window_ctrl.sv | 154 +++++++++++++++
 tb/tb_prbs15_ber_window_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs15_ber_window_ctrl.sv
// prbs15_ber_window_ctrl
// Measurement sequencer for a PRBS15 byte checker: clears the checker,
// qualifies lock, measures over a fixed window of cycles and reports the
// error count as the difference of two snapshots of the checker's
// cumulative counter, so errors seen before lock never reach the result.
//
// Request/response protocol: start is a one-cycle request honoured only in
// IDLE (busy=0); there is no back-pressure and no queuing. Every accepted
// start produces exactly one done pulse, in the same cycle result_* and
// status update; result_valid stays high until the next accepted start.
//
// All outputs are registered from the next state so they line up with the
// state they describe. dbg_state mirrors the FSM state register.
module prbs15_ber_window_ctrl #(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_CYCLES  = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] window_len,
  input  logic [31:0] chk_bit_errors,
  input  logic        chk_locked,
  output logic        chk_reset,
  output logic        chk_stop,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [31:0] result_errors,
  output logic [39:0] result_bits,
  output logic [1:0]  status,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR      = 3'd1,
    S_LOCKWAIT = 3'd2,
    S_MEASURE  = 3'd3,
    S_FINISH   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [31:0] CLR_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] LOCK_RUN = 16'(LOCK_CYCLES);

  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_ERRORS  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORTED = 2'd3;

  state_t      state, state_nxt;
  logic [31:0] ph_cnt, ph_cnt_nxt;   // cycles spent in the current state
  logic [15:0] run_cnt, run_cnt_nxt; // consecutive locked cycles in LOCKWAIT
  logic [31:0] win_len;              // effective window length (never 0)
  logic [31:0] snap;                 // error counter at first MEASURE cycle
  logic [31:0] err_diff;
  logic        end_abort, end_timeout, end_normal;

  // Modular difference absorbs a single wrap of the checker's counter.
  assign err_diff  = chk_bit_errors - snap;
  assign dbg_state = state;

  // Next-state logic; abort overrides every other transition of a busy run.
  always_comb begin
    state_nxt   = state;
    end_abort   = 1'b0;
    end_timeout = 1'b0;
    end_normal  = 1'b0;
    run_cnt_nxt = chk_locked ? run_cnt + 16'd1 : 16'd0;
    case (state)
      S_IDLE:     if (start) state_nxt = S_CLR;
      S_CLR:      if (ph_cnt == CLR_LAST) state_nxt = S_LOCKWAIT;
      S_LOCKWAIT: begin
        // A lock completing on the timeout cycle still counts as lock.
        if (run_cnt_nxt == LOCK_RUN) begin
          state_nxt = S_MEASURE;
        end else if (ph_cnt == TMO_LAST) begin
          state_nxt   = S_DONE;
          end_timeout = 1'b1;
        end
      end
      S_MEASURE:  if (ph_cnt == win_len - 32'd1) state_nxt = S_FINISH;
      S_FINISH: begin
        if (ph_cnt == 32'd1) begin
          state_nxt  = S_DONE;
          end_normal = 1'b1;
        end
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    // DONE is left alone: the run has already produced its result.
    if (abort && (state inside {S_CLR, S_LOCKWAIT, S_MEASURE, S_FINISH})) begin
      state_nxt   = S_DONE;
      end_abort   = 1'b1;
      end_timeout = 1'b0;
      end_normal  = 1'b0;
    end
    ph_cnt_nxt = ((state_nxt != state) || (state == S_IDLE)) ? 32'd0 : ph_cnt + 32'd1;
  end

  // State, counters, snapshots and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      ph_cnt        <= 32'd0;
      run_cnt       <= 16'd0;
      win_len       <= 32'd1;
      snap          <= 32'd0;
      chk_reset     <= 1'b1;
      chk_stop      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      result_errors <= 32'd0;
      result_bits   <= 40'd0;
      status        <= ST_PASS;
    end else begin
      state     <= state_nxt;
      ph_cnt    <= ph_cnt_nxt;
      run_cnt   <= ((state == S_LOCKWAIT) && (state_nxt == S_LOCKWAIT)) ? run_cnt_nxt : 16'd0;
      chk_reset <= (state_nxt == S_CLR);
      chk_stop  <= !(state_nxt inside {S_CLR, S_LOCKWAIT, S_MEASURE});
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);

      if ((state == S_IDLE) && start) begin
        result_valid <= 1'b0;
        win_len      <= (window_len == 32'd0) ? 32'd1 : window_len;
      end

      if ((state == S_MEASURE) && (ph_cnt == 32'd0)) begin
        snap <= chk_bit_errors;
      end

      if (end_abort || end_timeout) begin
        result_valid  <= 1'b1;
        result_errors <= 32'd0;
        result_bits   <= 40'd0;
        status        <= end_abort ? ST_ABORTED : ST_TIMEOUT;
      end else if (end_normal) begin
        result_valid  <= 1'b1;
        result_errors <= err_diff;
        result_bits   <= {8'h00, win_len} << 3;
        status        <= (err_diff != 32'd0) ? ST_ERRORS : ST_PASS;
      end
    end
  end

endmodule

// File: tb/tb_prbs15_ber_window_ctrl.sv
// tb_prbs15_ber_window_ctrl
// Drives scripted checker behaviour (per-cycle locked flag and error
// increments) and compares against a timeline model of the measurement.
module tb_prbs15_ber_window_ctrl;

  localparam int RST_CYCLES   = 8;
  localparam int LOCK_CYCLES  = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int NCYC         = 8192;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] window_len;
  logic [31:0] chk_bit_errors;
  logic        chk_locked;
  logic        chk_reset;
  logic        chk_stop;
  logic        busy;
  logic        done;
  logic        result_valid;
  logic [31:0] result_errors;
  logic [39:0] result_bits;
  logic [1:0]  status;
  logic [2:0]  dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Script indexed by cycle number after the accepted start (cycle 1 = first CLR cycle).
  bit          lk_arr  [NCYC];
  logic [31:0] inc_arr [NCYC];

  prbs15_ber_window_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .window_len    (window_len),
    .chk_bit_errors(chk_bit_errors),
    .chk_locked    (chk_locked),
    .chk_reset     (chk_reset),
    .chk_stop      (chk_stop),
    .busy          (busy),
    .done          (done),
    .result_valid  (result_valid),
    .result_errors (result_errors),
    .result_bits   (result_bits),
    .status        (status),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] val_at(input logic [31:0] base, input int c);
    logic [31:0] v;
    v = base;
    for (int k = 1; k <= c; k++) v = v + inc_arr[k];
    return v;
  endfunction

  // Timeline: LOCKWAIT starts after the clear phase; measurement starts the
  // cycle after the 16th consecutive locked cycle; result appears two cycles
  // after the window; abort ends the run one cycle after it is seen.
  function automatic void model_run(input logic [31:0] wlen, input logic [31:0] base,
                                    input int abort_cyc, output int d_cyc, output int m_cyc,
                                    output logic [1:0] st, output logic [31:0] er,
                                    output logic [39:0] bt);
    longint w;
    int l, run;
    w = (wlen == 32'd0) ? 1 : longint'(wlen);
    l = RST_CYCLES + 1;
    run = 0;
    m_cyc = -1;
    for (int c = l; c < l + LOCK_TIMEOUT; c++) begin
      run = lk_arr[c] ? run + 1 : 0;
      if (run == LOCK_CYCLES) begin
        m_cyc = c + 1;
        break;
      end
    end
    if (m_cyc < 0) begin
      d_cyc = l + LOCK_TIMEOUT;
      st = 2'd2; er = 32'd0; bt = 40'd0;
    end else begin
      d_cyc = m_cyc + int'(w) + 2;
      er = val_at(base, m_cyc + int'(w) + 1) - val_at(base, m_cyc);
      st = (er != 32'd0) ? 2'd1 : 2'd0;
      bt = 40'(w) * 40'd8;
    end
    if (abort_cyc > 0 && abort_cyc < d_cyc) begin
      d_cyc = abort_cyc + 1;
      st = 2'd3; er = 32'd0; bt = 40'd0;
    end
  endfunction

  task automatic clear_script();
    for (int i = 0; i < NCYC; i++) begin
      lk_arr[i]  = 1'b0;
      inc_arr[i] = 32'd0;
    end
  endtask

  task automatic fill_lock(input int from);
    for (int i = from; i < NCYC; i++) lk_arr[i] = 1'b1;
  endtask

  // Driver + inline checks for one full run. Starts and ends at a posedge.
  task automatic run_case(input string name, input logic [31:0] wlen, input logic [31:0] base,
                          input int abort_cyc, input bit noise);
    int d_cyc, m_cyc, got, n_done;
    logic [1:0]  st;
    logic [31:0] er, cur;
    logic [39:0] bt;
    model_run(wlen, base, abort_cyc, d_cyc, m_cyc, st, er, bt);
    got = -1; n_done = 0; cur = base;
    #1;
    start = 1'b1; window_len = wlen; chk_bit_errors = base; chk_locked = 1'b0; abort = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= d_cyc + 2; c++) begin
      #1;
      start          = (noise && c <= d_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      window_len     = $urandom();
      cur            = cur + inc_arr[c];
      chk_bit_errors = cur;
      chk_locked     = lk_arr[c];
      abort          = (c == abort_cyc);
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (got < 0) got = c;
      end
      if (c == 1) begin
        chk_cnt++;
        if (busy !== 1'b1 || result_valid !== 1'b0 || chk_reset !== 1'b1) begin
          err_cnt++;
          $display("FAIL %s clr_entry: busy=%b valid=%b chk_reset=%b want 1 0 1", name, busy, result_valid, chk_reset);
        end
      end
      if (c == m_cyc && m_cyc > 0 && (abort_cyc == 0 || abort_cyc >= m_cyc)) begin
        chk_cnt++;
        if (chk_stop !== 1'b0 || chk_reset !== 1'b0 || busy !== 1'b1) begin
          err_cnt++;
          $display("FAIL %s measure_entry: stop=%b reset=%b busy=%b want 0 0 1", name, chk_stop, chk_reset, busy);
        end
      end
      if (c == d_cyc) begin
        chk_cnt++;
        if (status !== st) begin
          err_cnt++;
          $display("FAIL %s status: got %0d want %0d", name, status, st);
        end
        chk_cnt++;
        if (result_errors !== er) begin
          err_cnt++;
          $display("FAIL %s result_errors: got %0d want %0d", name, result_errors, er);
        end
        chk_cnt++;
        if (result_bits !== bt) begin
          err_cnt++;
          $display("FAIL %s result_bits: got %0d want %0d", name, result_bits, bt);
        end
        chk_cnt++;
        if (result_valid !== 1'b1 || chk_stop !== 1'b1 || busy !== 1'b1 || chk_reset !== 1'b0) begin
          err_cnt++;
          $display("FAIL %s done_flags: valid=%b stop=%b busy=%b reset=%b want 1 1 1 0", name, result_valid, chk_stop, busy, chk_reset);
        end
      end
      if (c == d_cyc + 1) begin
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b1 || chk_stop !== 1'b1) begin
          err_cnt++;
          $display("FAIL %s idle_after: busy=%b done=%b valid=%b stop=%b want 0 0 1 1", name, busy, done, result_valid, chk_stop);
        end
      end
      @(posedge clk);
    end
    #1;
    abort = 1'b0; start = 1'b0;
    chk_cnt++;
    if (got != d_cyc || n_done != 1) begin
      err_cnt++;
      $display("FAIL %s done_timing: first done at cycle %0d (%0d pulses) want cycle %0d (1 pulse)", name, got, n_done, d_cyc);
    end
    @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; window_len = 32'd0;
    chk_bit_errors = 32'd0; chk_locked = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (chk_reset !== 1'b1 || chk_stop !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        result_valid !== 1'b0 || result_errors !== 32'd0 || result_bits !== 40'd0 ||
        status !== 2'd0 || dbg_state !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_values: rst=%b stop=%b busy=%b done=%b valid=%b err=%0d bits=%0d st=%0d state=%0d",
               chk_reset, chk_stop, busy, done, result_valid, result_errors, result_bits, status, dbg_state);
    end
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (chk_reset !== 1'b0 || chk_stop !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: chk_reset=%b stop=%b busy=%b want 0 1 0", chk_reset, chk_stop, busy);
    end
    @(posedge clk);
  endtask

  task automatic test_clean();
    clear_script();
    fill_lock(1);
    run_case("clean", 32'd1000, $urandom(), 0, 1'b0);
  endtask

  task automatic test_errors();
    int w;
    clear_script();
    fill_lock(1);
    lk_arr[12]  = 1'b0;
    inc_arr[12] = 32'd1;
    w = $urandom_range(50, 300);
    for (int k = 0; k < 3; k++) begin
      int c;
      c = 30 + $urandom_range(0, w - 1);
      inc_arr[c] = inc_arr[c] + 32'd1;
    end
    run_case("errors", 32'(w), $urandom(), 0, 1'b0);
  endtask

  task automatic test_timeout();
    clear_script();
    for (int c = 1; c < NCYC; c++) lk_arr[c] = ((c % 16) != 0);
    run_case("timeout", 32'($urandom_range(1, 500)), $urandom(), 0, 1'b0);
    clear_script();
    run_case("timeout_low", 32'd10, 32'd0, 0, 1'b0);
  endtask

  task automatic test_relock();
    clear_script();
    fill_lock(1);
    lk_arr[24] = 1'b0;
    inc_arr[30] = 32'd2;
    run_case("relock", 32'd40, $urandom(), 0, 1'b0);
  endtask

  task automatic test_wrap();
    clear_script();
    fill_lock(1);
    for (int k = 0; k < 5; k++) inc_arr[26 + 15 * k] = 32'd1;
    run_case("wrap", 32'd100, 32'hFFFF_FFFE, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_script();
      for (int c = 9; c <= 60; c++) lk_arr[c] = ($urandom_range(0, 7) != 0);
      fill_lock(61);
      for (int c = 1; c < 400; c++)
        inc_arr[c] = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
      run_case("random", (it == 0) ? 32'd0 : 32'($urandom_range(1, 200)), $urandom(), 0, 1'b0);
    end
  endtask

  task automatic test_abort();
    #1 abort = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_idle: busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk);
    #1 abort = 1'b0;
    @(posedge clk);
    clear_script();
    fill_lock(1);
    for (int c = 20; c < 300; c += 7) inc_arr[c] = 32'd1;
    run_case("abort_clr", 32'd50, $urandom(), 3, 1'b1);
    run_case("abort_lockwait", 32'd50, $urandom(), 15, 1'b1);
    run_case("abort_measure", 32'd200, $urandom(), 25 + $urandom_range(0, 199), 1'b1);
    run_case("abort_finish", 32'd20, $urandom(), 46, 1'b1);
  endtask

  task automatic test_back_to_back();
    clear_script();
    fill_lock(1);
    for (int c = 30; c < 200; c += 11) inc_arr[c] = 32'd1;
    run_case("b2b_a", 32'd120, $urandom(), 0, 1'b1);
    run_case("b2b_b", 32'd60, $urandom(), 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] cur;
    clear_script();
    fill_lock(1);
    cur = 32'd0;
    #1;
    start = 1'b1; window_len = 32'd500; chk_bit_errors = cur; chk_locked = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      #1;
      start = 1'b0; chk_locked = lk_arr[c];
      @(posedge clk);
    end
    #3 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (chk_reset !== 1'b1 || busy !== 1'b0 || chk_stop !== 1'b1 || done !== 1'b0 ||
        result_valid !== 1'b0 || status !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_mid: chk_reset=%b busy=%b stop=%b done=%b valid=%b st=%0d want 1 0 1 0 0 0",
               chk_reset, busy, chk_stop, done, result_valid, status);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (chk_reset !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_release: chk_reset=%b busy=%b want 0 0", chk_reset, busy);
    end
    @(posedge clk);
    run_case("after_reset", 32'd30, $urandom(), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_errors();
    test_timeout();
    test_relock();
    test_wrap();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
